// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: START, DATA, optional PARITY, STOP; Moore outputs; START one cycle after accept.
// No backpressure: data_valid is taken only in IDLE or the last STOP cycle, otherwise dropped.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             stop_cnt, stop_cnt_nxt;
  logic             par_en_r, par_en_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par_en_r <= par_en_nxt;
    end
  end

  // Outputs decode state and counters only; inputs affect next-state values alone.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_en_nxt   = par_en_r;
    ser_en       = 1'b0;
    mux_sel      = 2'b01;
    busy         = 1'b0;
    frame_done   = 1'b0;

    case (state)
      S_IDLE: begin
        if (data_valid) begin
          state_nxt  = S_START;
          par_en_nxt = par_en;
        end
      end
      S_START: begin
        mux_sel     = 2'b00;
        busy        = 1'b1;
        state_nxt   = S_DATA;
        bit_cnt_nxt = '0;
      end
      S_DATA: begin
        mux_sel = 2'b10;
        ser_en  = 1'b1;
        busy    = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          state_nxt    = par_en_r ? S_PARITY : S_STOP;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        mux_sel      = 2'b11;
        busy         = 1'b1;
        state_nxt    = S_STOP;
        stop_cnt_nxt = 1'b0;
      end
      S_STOP: begin
        busy = 1'b1;
        if (stop_cnt == STOP_LAST) begin
          frame_done   = 1'b1;
          stop_cnt_nxt = 1'b0;
          // A request here chains the next frame with no idle bit in between.
          if (data_valid) begin
            state_nxt  = S_START;
            par_en_nxt = par_en;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          stop_cnt_nxt = stop_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        bit_cnt_nxt  = '0;
        stop_cnt_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench: one DUT with 1 stop bit, one with 2; outputs compared per cycle as
// {busy, ser_en, frame_done, mux_sel}.
module tb_uart_tx_fsm;

  localparam logic [4:0] E_IDLE  = 5'b000_01;
  localparam logic [4:0] E_START = 5'b100_00;
  localparam logic [4:0] E_DATA  = 5'b110_10;
  localparam logic [4:0] E_PAR   = 5'b100_11;
  localparam logic [4:0] E_STOP  = 5'b100_01;
  localparam logic [4:0] E_LAST  = 5'b101_01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       ser_en1, busy1, fd1;
  logic [1:0] mux1;
  logic       ser_en2, busy2, fd2;
  logic [1:0] mux2;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  int busy_low = 0;

  always #5 clk = ~clk;

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .data_valid(data_valid), .par_en(par_en),
    .ser_en(ser_en1), .mux_sel(mux1), .busy(busy1), .frame_done(fd1)
  );

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .data_valid(data_valid), .par_en(par_en),
    .ser_en(ser_en2), .mux_sel(mux2), .busy(busy2), .frame_done(fd2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs(input bit sel);
    return sel ? {busy2, ser_en2, fd2, mux2} : {busy1, ser_en1, fd1, mux1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string tag, input bit sel, input logic [4:0] exp);
    logic [4:0] v;
    v = obs(sel);
    if (v[2]) fd_cnt++;
    if (!v[4]) busy_low++;
    chk(tag, 32'(v), 32'(exp));
  endtask

  // Caller raises data_valid before the call; the accept edge is the first step here.
  task automatic frame(input string tag, input bit sel, input bit par, input int nstop,
                       input bit keep_dv, input bit poke_data, input bit poke_stop);
    step();
    chk_obs({tag, "/start"}, sel, E_START);
    if (!keep_dv) data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_obs($sformatf("%s/data%0d", tag, i), sel, E_DATA);
      if (poke_data && i == 3) begin
        data_valid = 1'b1;
        par_en     = ~par_en;
      end
      if (poke_data && i == 4) data_valid = keep_dv;
    end
    if (par) begin
      step();
      chk_obs({tag, "/parity"}, sel, E_PAR);
    end
    for (int s = 0; s < nstop; s++) begin
      step();
      if (s == nstop - 1) begin
        chk_obs({tag, "/stop_last"}, sel, E_LAST);
        if (poke_stop) data_valid = 1'b0;
      end else begin
        chk_obs($sformatf("%s/stop%0d", tag, s), sel, E_STOP);
        if (poke_stop) data_valid = 1'b1;
      end
    end
  endtask

  initial begin
    // 1: reset held, then released idle
    step();
    chk_obs("t1/in_reset", 0, E_IDLE);
    chk_obs("t1/in_reset2", 1, E_IDLE);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_obs($sformatf("t1/idle%0d", i), 0, E_IDLE);
    end

    // 2: plain frame, no parity
    par_en = 1'b0;
    data_valid = 1'b1;
    fd_cnt = 0;
    busy_low = 0;
    frame("t2", 0, 0, 1, 0, 0, 0);
    chk("t2/busy_low", busy_low, 0);
    step();
    chk_obs("t2/idle_after", 0, E_IDLE);
    chk("t2/fd_cnt", fd_cnt, 1);

    // 3: parity frame; mid-frame par_en toggle and data_valid pulse ignored
    par_en = 1'b1;
    data_valid = 1'b1;
    frame("t3", 0, 1, 1, 0, 1, 0);
    step();
    chk_obs("t3/idle_after", 0, E_IDLE);

    // 4: data_valid held, three back-to-back parity frames
    step();
    par_en = 1'b1;
    data_valid = 1'b1;
    fd_cnt = 0;
    busy_low = 0;
    frame("t4a", 0, 1, 1, 1, 0, 0);
    frame("t4b", 0, 1, 1, 1, 0, 0);
    frame("t4c", 0, 1, 1, 1, 0, 0);
    data_valid = 1'b0;
    chk("t4/fd_cnt", fd_cnt, 3);
    chk("t4/busy_low", busy_low, 0);
    step();
    chk_obs("t4/idle_after", 0, E_IDLE);
    step();

    // 6: reset in DATA cycle 4 aborts at once, then a clean frame follows
    par_en = 1'b1;
    data_valid = 1'b1;
    step();
    chk_obs("t6/start", 0, E_START);
    data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_obs($sformatf("t6/data%0d", i), 0, E_DATA);
    end
    reset = 1'b0;
    #1;
    chk_obs("t6/abort", 0, E_IDLE);
    step();
    chk_obs("t6/held", 0, E_IDLE);
    reset = 1'b1;
    step();
    chk_obs("t6/released", 0, E_IDLE);
    par_en = 1'b0;
    data_valid = 1'b1;
    frame("t6f", 0, 0, 1, 0, 0, 0);
    step();
    chk_obs("t6/idle_after", 0, E_IDLE);

    // 5: two stop bits, data_valid in the first stop cycle ignored
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_obs("t5/idle_before", 1, E_IDLE);
    par_en = 1'b0;
    data_valid = 1'b1;
    fd_cnt = 0;
    frame("t5", 1, 0, 2, 0, 0, 1);
    step();
    chk_obs("t5/idle_after", 1, E_IDLE);
    step();
    chk_obs("t5/idle_after2", 1, E_IDLE);
    chk("t5/fd_cnt", fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
